// File: rtl/lcd_display_scanner_pkg.sv
// rtl/lcd_display_scanner_pkg.sv - shared display scanner types and column layout
package lcd_display_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_EMIT,
        ST_NEXT
    } state_t;

    localparam logic [7:0] COLON_CHAR     = 8'h3A;

    // Each rendered block is "NNNNN:HHHHHHHH": name, separator, eight hex digits
    localparam logic [3:0] NAME_COL_FIRST = 4'd0;
    localparam logic [3:0] NAME_COL_LAST  = 4'd4;
    localparam logic [3:0] SEP_COL        = 4'd5;
    localparam logic [3:0] HEX_COL_FIRST  = 4'd6;
    localparam logic [3:0] HEX_COL_LAST   = 4'd13;

endpackage

// File: rtl/lcd_display_scanner_if.sv
// rtl/lcd_display_scanner_if.sv - provider request/response and character stream bundle
interface lcd_display_scanner_if;

    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;

    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [5:0]  char_block;
    logic [3:0]  char_col;

    modport master (
        output display_number,
        input  display_valid,
        input  display_name,
        input  display_value,
        output char_valid,
        output char_data,
        output char_block,
        output char_col,
        input  char_ready
    );

    modport slave (
        input  display_number,
        output display_valid,
        output display_name,
        output display_value,
        input  char_valid,
        input  char_data,
        input  char_block,
        input  char_col,
        output char_ready
    );

endinterface

// File: rtl/lcd_display_scanner_hex_to_ascii.sv
// rtl/lcd_display_scanner_hex_to_ascii.sv - nibble to uppercase ASCII hex digit
module hex_to_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // 0-9 map to '0'-'9', 10-15 map to 'A'-'F'
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/lcd_display_scanner.sv
// rtl/lcd_display_scanner.sv - scans display blocks and streams their text characters
module lcd_display_scanner
    import lcd_display_scanner_pkg::*;
#(
    parameter int NUM_BLOCKS = 44,
    parameter int RESP_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  scan_en,
    lcd_display_scanner_if.master disp,
    output logic                  frame_done,
    output logic                  busy
);

    state_t      state_q, state_d;
    logic [5:0]  number_q, number_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  col_q, col_d;

    logic        cap_valid_q;
    logic [39:0] cap_name_q;
    logic [31:0] cap_value_q;

    logic        char_valid;
    logic        transfer;
    logic [2:0]  hex_idx;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;
    logic [7:0]  name_char;

    assign char_valid = (state_q == ST_EMIT) && cap_valid_q;
    assign transfer   = char_valid && disp.char_ready;

    // Hex column 6 carries the most significant nibble, column 13 the least
    assign hex_idx = 3'(HEX_COL_LAST - col_q);
    assign nibble  = cap_value_q[{hex_idx, 2'b00} +: 4];

    hex_to_ascii u_hex_to_ascii (
        .nibble_i (nibble),
        .ascii_o  (hex_char)
    );

    // Name byte for the current column, leftmost character first
    always_comb begin
        name_char = 8'h00;
        case (col_q)
            4'd0:    name_char = cap_name_q[39:32];
            4'd1:    name_char = cap_name_q[31:24];
            4'd2:    name_char = cap_name_q[23:16];
            4'd3:    name_char = cap_name_q[15:8];
            4'd4:    name_char = cap_name_q[7:0];
            default: name_char = 8'h00;
        endcase
    end

    // State, block counter, response-latency counter and column registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            number_q <= 6'd0;
            wait_q   <= 3'd0;
            col_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            wait_q   <= wait_d;
            col_q    <= col_d;
        end
    end

    // Provider response is taken only in CAPTURE so later changes cannot leak into the text
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cap_valid_q <= 1'b0;
            cap_name_q  <= 40'd0;
            cap_value_q <= 32'd0;
        end else if (state_q == ST_CAPTURE) begin
            cap_valid_q <= disp.display_valid;
            cap_name_q  <= disp.display_name;
            cap_value_q <= disp.display_value;
        end
    end

    // Next-state logic; scan_en only matters in IDLE and at frame end
    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        wait_d   = wait_q;
        col_d    = col_q;
        case (state_q)
            ST_IDLE: begin
                number_d = 6'd0;
                if (scan_en) begin
                    number_d = 6'd1;
                    wait_d   = 3'd0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 3'(RESP_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                col_d   = NAME_COL_FIRST;
                state_d = disp.display_valid ? ST_EMIT : ST_NEXT;
            end
            ST_EMIT: begin
                if (transfer) begin
                    if (col_q == HEX_COL_LAST) begin
                        col_d   = 4'd0;
                        state_d = ST_NEXT;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            ST_NEXT: begin
                wait_d = 3'd0;
                col_d  = 4'd0;
                if (number_q != 6'(NUM_BLOCKS)) begin
                    number_d = number_q + 6'd1;
                    state_d  = ST_WAIT;
                end else if (scan_en) begin
                    number_d = 6'd1;
                    state_d  = ST_WAIT;
                end else begin
                    number_d = 6'd0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                number_d = 6'd0;
            end
        endcase
    end

    // Character stream and status outputs; character fields read zero outside EMIT
    always_comb begin
        disp.display_number = number_q;
        disp.char_valid     = char_valid;
        disp.char_col       = col_q;
        disp.char_block     = 6'd0;
        disp.char_data      = 8'h00;
        if (char_valid) begin
            disp.char_block = number_q;
            if (col_q <= NAME_COL_LAST) begin
                disp.char_data = name_char;
            end else if (col_q == SEP_COL) begin
                disp.char_data = COLON_CHAR;
            end else if (col_q >= HEX_COL_FIRST) begin
                disp.char_data = hex_char;
            end
        end
        frame_done = (state_q == ST_NEXT) && (number_q == 6'(NUM_BLOCKS));
        busy       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_lcd_display_scanner.sv
// tb/tb_lcd_display_scanner.sv - directed self-checking bench for lcd_display_scanner
module tb_lcd_display_scanner;

    logic clk = 1'b0;
    logic resetn;
    logic scan_en;
    logic frame_done;
    logic busy;

    int total = 0;
    int bad   = 0;

    logic        prov_valid [0:63];
    logic [39:0] prov_name  [0:63];
    logic [31:0] prov_value [0:63];

    lcd_display_scanner_if bus ();

    lcd_display_scanner #(
        .NUM_BLOCKS (44),
        .RESP_LAT   (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .scan_en    (scan_en),
        .disp       (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #50 clk = ~clk;

    assign bus.display_valid = prov_valid[bus.display_number];
    assign bus.display_name  = prov_name[bus.display_number];
    assign bus.display_value = prov_value[bus.display_number];

    task automatic test_reset();
        resetn = 1'b0;
        scan_en = 1'b0;
        bus.char_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.char_valid !== 1'b0) begin bad++; $display("FAIL reset_char_valid got=%b want=0", bus.char_valid); end
        total++; if (bus.display_number !== 6'd0) begin bad++; $display("FAIL reset_display_number got=%0d want=0", bus.display_number); end
        total++; if (bus.char_data !== 8'h00) begin bad++; $display("FAIL reset_char_data got=%h want=00", bus.char_data); end
        total++; if (bus.char_block !== 6'd0) begin bad++; $display("FAIL reset_char_block got=%0d want=0", bus.char_block); end
        total++; if (bus.char_col !== 4'd0) begin bad++; $display("FAIL reset_char_col got=%0d want=0", bus.char_col); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        resetn = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || bus.display_number !== 6'd0) begin bad++; $display("FAIL idle_hold got busy=%b num=%0d want busy=0 num=0", busy, bus.display_number); end
    endtask

    task automatic test_first_block();
        string exp;
        int    cyc;
        bit    found;
        exp = "IF_PC:0000001C";
        scan_en = 1'b1;
        bus.char_ready = 1'b1;
        cyc = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.char_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found || cyc != 4) begin bad++; $display("FAIL first_latency got found=%0d cycles=%0d want cycles=4", found, cyc); end
        for (int i = 0; i < 14; i++) begin
            total++;
            if (bus.char_valid !== 1'b1 || bus.char_col !== 4'(i) || bus.char_block !== 6'd1 || bus.char_data !== exp[i]) begin
                bad++;
                $display("FAIL first_char%0d got valid=%b data=%h col=%0d blk=%0d want data=%h col=%0d blk=1", i, bus.char_valid, bus.char_data, bus.char_col, bus.char_block, exp[i], i);
            end
            @(negedge clk);
        end
        total++; if (bus.char_valid !== 1'b0) begin bad++; $display("FAIL first_after_col13 got valid=%b want=0", bus.char_valid); end
    endtask

    task automatic test_stall();
        string exp;
        bit    found;
        exp = "STALL:DEADBEEF";
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1 && bus.char_block === 6'd2) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL stall_start got no block 2 char want char_valid"); end
        for (int c = 0; c < 14; c++) begin
            total++;
            if (bus.char_valid !== 1'b1 || bus.char_col !== 4'(c) || bus.char_block !== 6'd2 || bus.char_data !== exp[c]) begin
                bad++;
                $display("FAIL stall_char%0d got valid=%b data=%h col=%0d blk=%0d want data=%h col=%0d blk=2", c, bus.char_valid, bus.char_data, bus.char_col, bus.char_block, exp[c], c);
            end
            if (c == 7) begin
                bus.char_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    total++;
                    if (bus.char_valid !== 1'b1 || bus.char_col !== 4'd7 || bus.char_data !== 8'h45) begin
                        bad++;
                        $display("FAIL stall_hold%0d got valid=%b data=%h col=%0d want valid=1 data=45 col=7", k, bus.char_valid, bus.char_data, bus.char_col);
                    end
                end
                bus.char_ready = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_capture_isolation();
        string exp;
        bit    found;
        exp = "CAPTR:12345678";
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1 && bus.char_block === 6'd3) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL capture_start got no block 3 char want char_valid"); end
        prov_value[3] = 32'hFFFF_FFFF;
        prov_name[3]  = "ZZZZZ";
        for (int c = 0; c < 14; c++) begin
            total++;
            if (bus.char_valid !== 1'b1 || bus.char_col !== 4'(c) || bus.char_data !== exp[c]) begin
                bad++;
                $display("FAIL capture_char%0d got valid=%b data=%h col=%0d want data=%h col=%0d", c, bus.char_valid, bus.char_data, bus.char_col, exp[c], c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_skip_and_wrap();
        int   hits10;
        int   extra_pulses;
        bit   seen11;
        bit   found;
        logic [5:0] num_at_pulse;
        hits10 = 0;
        extra_pulses = 0;
        seen11 = 1'b0;
        found = 1'b0;
        num_at_pulse = 6'd0;
        bus.char_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1 && bus.char_block === 6'd10) hits10++;
            if (bus.char_valid === 1'b1 && bus.char_block === 6'd11) seen11 = 1'b1;
            if (frame_done === 1'b1) begin
                found = 1'b1;
                num_at_pulse = bus.display_number;
                break;
            end
        end
        total++; if (!found || num_at_pulse !== 6'd44) begin bad++; $display("FAIL frame_pulse got found=%0d num=%0d want found=1 num=44", found, num_at_pulse); end
        total++; if (hits10 != 0) begin bad++; $display("FAIL skip_block10 got chars=%0d want=0", hits10); end
        total++; if (!seen11) begin bad++; $display("FAIL block11_emitted got=0 want=1"); end
        @(negedge clk);
        total++; if (frame_done !== 1'b0 || bus.display_number !== 6'd1 || busy !== 1'b1) begin bad++; $display("FAIL wrap got pulse=%b num=%0d busy=%b want pulse=0 num=1 busy=1", frame_done, bus.display_number, busy); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) extra_pulses++;
        end
        total++; if (extra_pulses != 0) begin bad++; $display("FAIL single_pulse got extra=%0d want=0", extra_pulses); end
    endtask

    task automatic test_scan_drop();
        bit   found;
        logic [5:0] maxblk;
        found = 1'b0;
        maxblk = 6'd0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bus.display_number === 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL drop_reach20 got=0 want=1"); end
        scan_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1 && bus.char_block > maxblk) maxblk = bus.char_block;
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found || maxblk !== 6'd44) begin bad++; $display("FAIL drop_complete got found=%0d lastblk=%0d want found=1 lastblk=44", found, maxblk); end
        @(negedge clk);
        total++; if (bus.display_number !== 6'd0 || busy !== 1'b0 || bus.char_valid !== 1'b0) begin bad++; $display("FAIL drop_idle got num=%0d busy=%b valid=%b want num=0 busy=0 valid=0", bus.display_number, busy, bus.char_valid); end
        repeat (5) @(negedge clk);
        total++; if (bus.display_number !== 6'd0 || busy !== 1'b0) begin bad++; $display("FAIL drop_stay_idle got num=%0d busy=%b want num=0 busy=0", bus.display_number, busy); end
    endtask

    task automatic test_reset_mid_emit();
        bit found;
        scan_en = 1'b1;
        bus.char_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1 && bus.char_col === 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL rst_reach_col3 got=0 want=1"); end
        resetn = 1'b0;
        @(negedge clk);
        total++; if (bus.char_valid !== 1'b0 || bus.display_number !== 6'd0 || busy !== 1'b0 || bus.char_col !== 4'd0) begin bad++; $display("FAIL rst_mid_emit got valid=%b num=%0d busy=%b col=%0d want 0 0 0 0", bus.char_valid, bus.display_number, busy, bus.char_col); end
        resetn = 1'b1;
        @(negedge clk);
        total++; if (bus.display_number !== 6'd1) begin bad++; $display("FAIL rst_restart_num got=%0d want=1", bus.display_number); end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.char_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found || bus.char_block !== 6'd1 || bus.char_col !== 4'd0 || bus.char_data !== 8'h49) begin bad++; $display("FAIL rst_restart_char got found=%0d blk=%0d col=%0d data=%h want blk=1 col=0 data=49", found, bus.char_block, bus.char_col, bus.char_data); end
    endtask

    initial begin
        for (int b = 0; b < 64; b++) begin
            prov_valid[b] = (b >= 1 && b <= 44 && b != 10);
            prov_name[b]  = "BLK__";
            prov_value[b] = 32'(b);
        end
        prov_name[1]  = "IF_PC";
        prov_value[1] = 32'h0000_001C;
        prov_name[2]  = "STALL";
        prov_value[2] = 32'hDEAD_BEEF;
        prov_name[3]  = "CAPTR";
        prov_value[3] = 32'h1234_5678;

        test_reset();
        test_first_block();
        test_stall();
        test_capture_isolation();
        test_skip_and_wrap();
        test_scan_drop();
        test_reset_mid_emit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
